// File: rtl/apb2wb_if.sv
// APB-side and Wishbone-side signal bundle for apb2wb_bridge.
// "slave" is the bridge's view; "master" is the view of the surrounding system.
interface apb2wb_if #(
  parameter int APB_AW = 7,
  parameter int WB_AW  = 5
);
  logic              apb_sel_i;
  logic              apb_enable_i;
  logic              apb_write_i;
  logic [APB_AW-1:0] apb_addr_i;
  logic [31:0]       apb_wdata_i;
  logic [31:0]       apb_rdata_o;
  logic              apb_ready_o;
  logic              apb_slverr_o;
  logic [WB_AW-1:0]  wb_adr_o;
  logic [31:0]       wb_dat_o;
  logic [31:0]       wb_dat_i;
  logic              wb_we_o;
  logic [3:0]        wb_sel_o;
  logic              wb_stb_o;
  logic              wb_cyc_o;
  logic              wb_ack_i;

  modport slave (
    input  apb_sel_i, apb_enable_i, apb_write_i, apb_addr_i, apb_wdata_i,
    input  wb_dat_i, wb_ack_i,
    output apb_rdata_o, apb_ready_o, apb_slverr_o,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport master (
    output apb_sel_i, apb_enable_i, apb_write_i, apb_addr_i, apb_wdata_i,
    output wb_dat_i, wb_ack_i,
    input  apb_rdata_o, apb_ready_o, apb_slverr_o,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/apb2wb_bridge.sv
// APB slave to Wishbone classic master bridge, one outstanding transfer at a time.
// Define APB2WB_TIMEOUT_EN to add an ack timeout that completes with apb_slverr_o=1.
module apb2wb_bridge #(
  parameter int APB_AW  = 7,
  parameter int WB_AW   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic     wb_clk_i,
  input  logic     wb_rst_i,
  apb2wb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WB, DONE} state_t;

  state_t            state, state_nxt;
  logic              start, ack_hit, timeout_hit;
  logic [WB_AW-1:0]  adr_q;
  logic [31:0]       dat_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       rdata_q;
  logic              ready_q;

  if (WB_AW > APB_AW || WB_AW < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("apb2wb_bridge: need 1 <= WB_AW <= APB_AW and TIMEOUT >= 1");
  end

  function automatic logic [3:0] lane_sel(input logic [1:0] lsb);
    return 4'b0001 << lsb;
  endfunction

  // Only a setup phase seen from IDLE launches a transfer; later APB activity is ignored.
  assign start   = (state == IDLE) && bus.apb_sel_i && !bus.apb_enable_i;
  assign ack_hit = (state == WB) && bus.wb_ack_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WB;
      WB:      if (ack_hit || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are latched once at setup and held through the whole Wishbone cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (start) begin
        adr_q <= bus.apb_addr_i[WB_AW-1:0];
        dat_q <= bus.apb_wdata_i;
        we_q  <= bus.apb_write_i;
        sel_q <= lane_sel(bus.apb_addr_i[1:0]);
      end
      if (ack_hit && !we_q) rdata_q <= bus.wb_dat_i;
      else if (timeout_hit) rdata_q <= '0;
      // An abandoned APB access (sel dropped) leaves DONE without a ready pulse.
      ready_q <= (state == DONE) && bus.apb_sel_i;
    end
  end

`ifdef APB2WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             slverr_q;

  // wait_cnt holds the number of WB cycles already elapsed; ack on the last cycle still wins.
  assign timeout_hit = (state == WB) && !bus.wb_ack_i && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
      slverr_q <= 1'b0;
    end else begin
      if (start)              wait_cnt <= '0;
      else if (state == WB)   wait_cnt <= wait_cnt + CNT_W'(1);
      if (start)              err_q <= 1'b0;
      else if (timeout_hit)   err_q <= 1'b1;
      slverr_q <= (state == DONE) && bus.apb_sel_i && err_q;
    end
  end

  assign bus.apb_slverr_o = slverr_q;
`else
  assign timeout_hit      = 1'b0;
  assign bus.apb_slverr_o = 1'b0;
`endif

  assign bus.wb_cyc_o    = (state == WB);
  assign bus.wb_stb_o    = (state == WB);
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_o    = dat_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_sel_o    = sel_q;
  assign bus.apb_rdata_o = rdata_q;
  assign bus.apb_ready_o = ready_q;

endmodule
